// File: rtl/byte_store_unit.sv
// Store-side narrowing unit: byte stores (with overflow flag) and word stores
// serialized as two little-endian byte writes. Optional macro BYTE_STORE_SAT_EN saturates overflowing bytes.
module byte_store_unit #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_word,
   input  logic [AW-1:0] req_addr,
   input  logic [15:0]   req_data,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic          mem_ack,
   output logic          done,
   output logic          ovf
);

   typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

   state_t        state_q, state_d;
   logic          word_q, word_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          byte_ovf;
   logic [7:0]    lo_byte;

   // Bits 15:7 must all match for the byte to sign-extend back to the word.
   assign byte_ovf = (|data_q[15:7]) & ~(&data_q[15:7]);

`ifdef BYTE_STORE_SAT_EN
   assign lo_byte = (word_q || !byte_ovf) ? data_q[7:0] : (data_q[15] ? 8'h80 : 8'h7F);
`else
   assign lo_byte = data_q[7:0];
`endif

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: if (req_valid) begin
            word_d  = req_word;
            addr_d  = req_addr;
            data_d  = req_data;
            state_d = LO;
         end
         LO:   if (mem_ack) state_d = word_q ? HI : FIN;
         HI:   if (mem_ack) state_d = FIN;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode only registered state, so nothing flows from inputs to outputs.
   always_comb begin
      req_ready = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      done      = 1'b0;
      ovf       = 1'b0;
      unique case (state_q)
         IDLE: req_ready = 1'b1;
         LO: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = lo_byte;
         end
         HI: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q + AW'(1);
            mem_wdata = data_q[15:8];
         end
         FIN: begin
            done = 1'b1;
            ovf  = ~word_q & byte_ovf;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         word_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_byte_store_unit.sv
// Randomized self-checking bench for byte_store_unit against a spec-level store model.
module tb_byte_store_unit;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready, req_word;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_ack, done, ovf;

   int checks = 0;
   int errors = 0;

   byte_store_unit #(.AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_word(req_word),
      .req_addr(req_addr), .req_data(req_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: signed range test on the integer value, not on bit patterns.
   function automatic bit model_ovf(input logic [15:0] d);
      int v;
      v = int'($signed(d));
      return (v > 127) || (v < -128);
   endfunction

   function automatic logic [7:0] model_byte(input logic [15:0] d);
      int v;
      v = int'($signed(d));
`ifdef BYTE_STORE_SAT_EN
      if (v > 127)  return 8'h7F;
      if (v < -128) return 8'h80;
`endif
      return d[7:0];
   endfunction

   // Full store transaction in lockstep; stall0/stall1 = cycles mem_ack is withheld per write.
   task automatic store(input string tag, input bit word, input logic [15:0] addr,
                        input logic [15:0] data, input int stall0, input int stall1);
      logic [AW-1:0] wa [2];
      logic [7:0]    wd [2];
      int            nw, st;
      nw    = word ? 2 : 1;
      wa[0] = addr;
      wa[1] = AW'((int'(addr) + 1) % (1 << AW));
      wd[0] = word ? data[7:0] : model_byte(data);
      wd[1] = data[15:8];
      req_valid = 1'b1; req_word = word; req_addr = addr; req_data = data;
      mem_ack = 1'b0;
      chk({tag, ":ready"}, 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_data  = 16'(($urandom));
      for (int k = 0; k < nw; k++) begin
         st = (k == 0) ? stall0 : stall1;
         for (int s = 0; s <= st; s++) begin
            mem_ack = (s == st);
            chk({tag, ":we"},    32'(mem_we),    32'd1);
            chk({tag, ":addr"},  32'(mem_addr),  32'(wa[k]));
            chk({tag, ":wdata"}, 32'(mem_wdata), 32'(wd[k]));
            chk({tag, ":nodone"}, 32'(done),     32'd0);
            chk({tag, ":busy"},  32'(req_ready), 32'd0);
            @(negedge clk);
         end
      end
      mem_ack = 1'b0;
      chk({tag, ":done"},   32'(done),      32'd1);
      chk({tag, ":ovf"},    32'(ovf),       32'(word ? 1'b0 : model_ovf(data)));
      chk({tag, ":we_fin"}, 32'(mem_we),    32'd0);
      chk({tag, ":rdy_fin"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      chk({tag, ":done1"},  32'(done),      32'd0);
      chk({tag, ":rdy_ret"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int dcount;
      logic [15:0] qa [2];
      logic [15:0] qd [2];
      int acc;
      reset_n = 1'b0; req_valid = 1'b0; req_word = 1'b0; req_addr = '0; req_data = '0; mem_ack = 1'b0;
      #12;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_we",    32'(mem_we),    32'd0);
      chk("rst_addr",  32'(mem_addr),  32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_ovf",   32'(ovf),       32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      store("byte_f3",  1'b0, 16'h0010, 16'hFFF3, 0, 0);
      store("word_124f", 1'b1, 16'h0020, 16'h124F, 0, 0);
      store("byte_0123", 1'b0, 16'h0030, 16'h0123, 0, 0);
      store("byte_fe00", 1'b0, 16'h0031, 16'hFE00, 1, 0);
      store("byte_007f", 1'b0, 16'h0032, 16'h007F, 0, 0);
      store("byte_ff80", 1'b0, 16'h0033, 16'hFF80, 0, 0);
      store("byte_0080", 1'b0, 16'h0034, 16'h0080, 0, 0);
      store("word_wrap", 1'b1, 16'hFFFF, 16'hA5C3, 3, 0);

      // Reset pulsed while the high byte is being written.
      req_valid = 1'b1; req_word = 1'b1; req_addr = 16'h0040; req_data = 16'h5678; mem_ack = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("rstmid_hi_we",   32'(mem_we),   32'd1);
      chk("rstmid_hi_addr", 32'(mem_addr), 32'h0041);
      reset_n = 1'b0;
      #1;
      chk("rstmid_we",    32'(mem_we),    32'd0);
      chk("rstmid_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) dcount++;
         @(negedge clk);
      end
      chk("rstmid_nodone", 32'(dcount), 32'd0);
      store("post_rst", 1'b0, 16'h0050, 16'h0042, 0, 0);

      // Two queued byte stores with req_valid held high throughout.
      qa[0] = 16'h0100; qd[0] = 16'h0011;
      qa[1] = 16'h0200; qd[1] = 16'hFF22;
      acc = 0; dcount = 0;
      mem_ack = 1'b1; req_valid = 1'b1; req_word = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (acc < 2) begin req_addr = qa[acc]; req_data = qd[acc]; end
         else req_valid = 1'b0;
         chk($sformatf("q_ready%0d", c), 32'(req_ready), 32'((c % 3) == 0));
         chk($sformatf("q_we%0d", c),    32'(mem_we),    32'((c % 3) == 1));
         chk($sformatf("q_done%0d", c),  32'(done),      32'((c % 3) == 2 && c < 6));
         if (c == 1 || c == 4) begin
            chk($sformatf("q_addr%0d", c),  32'(mem_addr),  32'(qa[c / 3]));
            chk($sformatf("q_wdata%0d", c), 32'(mem_wdata), 32'(model_byte(qd[c / 3])));
         end
         if (done) dcount++;
         if (req_ready && req_valid) acc++;
         @(negedge clk);
      end
      chk("q_dones", 32'(dcount), 32'd2);
      mem_ack = 1'b0; req_valid = 1'b0;

      // Randomized mix, biased toward the narrowing boundaries.
      for (int n = 0; n < 40; n++) begin
         logic [15:0] d;
         case ($urandom_range(0, 3))
            0: d = 16'($urandom);
            1: d = 16'($signed(9'($urandom)));
            2: d = 16'(int'($urandom_range(0, 3)) + 126);
            default: d = 16'(-129 + int'($urandom_range(0, 3)));
         endcase
         store($sformatf("rnd%0d", n), 1'($urandom), 16'($urandom),
               d, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
